dpll_lock_detect: RTL

Lock detector for the software-loaded digital PLL, sitting directly downstream of the phase-tracking stage. It consumes the PLL's 2-bit per-sample error code (00 = match, 01 = lag, 11 = lead) and counts mismatches over fixed windows of clock-enabled samples. It applies a hysteresis state machine to declare and drop lock, and reports the last window's error count and net lead/lag bias. Software can read these, and higher-level control can gate on lock.

---
 rtl/dpll_lock_detect_if.sv | 22 ++
 rtl/dpll_lock_detect.sv | 101 ++++++++++
 2 files changed

// File: rtl/dpll_lock_detect_if.sv
// dpll_lock_detect_if: per-sample inputs, thresholds and window results of the lock detector.
// master drives samples/thresholds; slave is the detector.
interface dpll_lock_detect_if #(parameter int LGWINDOW = 10);
  logic i_ce;
  logic [1:0] i_err;
  logic i_clear;
  logic [LGWINDOW:0] i_lock_thresh;
  logic [LGWINDOW:0] i_unlock_thresh;
  logic o_locked;
  logic [1:0] o_state;
  logic o_win_stb;
  logic [LGWINDOW:0] o_err_count;
  logic signed [LGWINDOW+1:0] o_bias;
  modport master (
    output i_ce, i_err, i_clear, i_lock_thresh, i_unlock_thresh,
    input o_locked, o_state, o_win_stb, o_err_count, o_bias
  );
  modport slave (
    input i_ce, i_err, i_clear, i_lock_thresh, i_unlock_thresh,
    output o_locked, o_state, o_win_stb, o_err_count, o_bias
  );
endinterface

// File: rtl/dpll_lock_detect.sv
// dpll_lock_detect: windowed PLL error counter with hysteresis lock FSM.
module dpll_lock_detect #(
  parameter int LGWINDOW = 10,
  parameter int LOCK_WINDOWS = 4,
  parameter int UNLOCK_WINDOWS = 2
) (
  input logic i_clk,
  input logic i_reset_n,
  dpll_lock_detect_if.slave bus
);
  typedef enum logic [1:0] {UNLOCKED, ACQUIRING, LOCKED, HOLD} state_t;
  state_t state;
  logic [LGWINDOW-1:0] cnt;
  logic [LGWINDOW:0] err_acc, err_nxt;
  logic signed [LGWINDOW+1:0] bias_acc, bias_nxt, bias_inc;
  logic [3:0] run, run_inc;
  logic last, good, bad;
  // accumulator values including the current sample, so the final sample lands in its own window
  always_comb begin
    bias_inc = bus.i_err == 2'b01 ? (LGWINDOW+2)'(1) : bus.i_err == 2'b11 ? '1 : '0;
    err_nxt = err_acc + (LGWINDOW+1)'(bus.i_err != 2'b00);
    bias_nxt = bias_acc + bias_inc;
    last = bus.i_ce && &cnt;
    good = err_nxt <= bus.i_lock_thresh;
    bad = err_nxt > bus.i_unlock_thresh;
    run_inc = run + 4'd1;
  end
  assign bus.o_state = state;
  assign bus.o_locked = state[1];
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= UNLOCKED;
      cnt <= '0;
      err_acc <= '0;
      bias_acc <= '0;
      run <= '0;
      bus.o_win_stb <= 1'b0;
      bus.o_err_count <= '0;
      bus.o_bias <= '0;
    end else if (bus.i_clear) begin
      state <= UNLOCKED;
      cnt <= '0;
      err_acc <= '0;
      bias_acc <= '0;
      run <= '0;
      bus.o_win_stb <= 1'b0;
    end else begin
      bus.o_win_stb <= last;
      if (bus.i_ce) begin
        cnt <= cnt + 1'b1;
        err_acc <= last ? '0 : err_nxt;
        bias_acc <= last ? '0 : bias_nxt;
      end
      // each state looks only at its own predicate; the gap between thresholds is the hysteresis band
      if (last) begin
        bus.o_err_count <= err_nxt;
        bus.o_bias <= bias_nxt;
        case (state)
          UNLOCKED:
            if (good) begin
              if (LOCK_WINDOWS == 1) begin
                state <= LOCKED;
                run <= 4'd0;
              end else begin
                state <= ACQUIRING;
                run <= 4'd1;
              end
            end
          ACQUIRING:
            if (!good) begin
              state <= UNLOCKED;
              run <= 4'd0;
            end else if (run_inc == 4'(LOCK_WINDOWS)) begin
              state <= LOCKED;
              run <= 4'd0;
            end else
              run <= run_inc;
          LOCKED:
            if (bad) begin
              if (UNLOCK_WINDOWS == 1) begin
                state <= UNLOCKED;
                run <= 4'd0;
              end else begin
                state <= HOLD;
                run <= 4'd1;
              end
            end else
              run <= 4'd0;
          HOLD:
            if (!bad) begin
              state <= LOCKED;
              run <= 4'd0;
            end else if (run_inc == 4'(UNLOCK_WINDOWS)) begin
              state <= UNLOCKED;
              run <= 4'd0;
            end else
              run <= run_inc;
        endcase
      end
    end
endmodule
